// File: rtl/ieee754_mult_dispatcher.sv
// Operand FIFO and start/done sequencer in front of the single-precision multiplier.
// Captures each product and its flags into a valid/ready register; a missing done becomes a timeout result.
module ieee754_mult_dispatcher #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [31:0]                  in_a_i,
   input  logic [31:0]                  in_b_i,
   output logic                         mul_start_o,
   output logic [31:0]                  mul_a_o,
   output logic [31:0]                  mul_b_o,
   input  logic                         mul_done_i,
   input  logic [31:0]                  mul_product_i,
   input  logic                         mul_nan_i,
   input  logic                         mul_inf_i,
   input  logic                         mul_ovf_i,
   input  logic                         mul_unf_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [31:0]                  out_product_o,
   output logic [4:0]                   out_flags_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         busy_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t          state_q, state_d;
   logic [31:0]     mem_a_q [DEPTH];
   logic [31:0]     mem_a_d [DEPTH];
   logic [31:0]     mem_b_q [DEPTH];
   logic [31:0]     mem_b_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic [WW-1:0]   wait_inc;
   logic            start_q, start_d;
   logic            out_valid_q, out_valid_d;
   logic [31:0]     out_product_q, out_product_d;
   logic [4:0]      out_flags_q, out_flags_d;
   logic            push;
   logic            pop;

   assign in_ready_o    = (count_q < CW'(DEPTH));
   assign mul_start_o   = start_q;
   assign mul_a_o       = (count_q != '0) ? mem_a_q[rd_ptr_q] : 32'h0;
   assign mul_b_o       = (count_q != '0) ? mem_b_q[rd_ptr_q] : 32'h0;
   assign out_valid_o   = out_valid_q;
   assign out_product_o = out_product_q;
   assign out_flags_o   = out_flags_q;
   assign count_o       = count_q;
   assign busy_o        = (state_q != IDLE) || (count_q != '0);

   // The FIFO head stays put until a result is captured, so the multiplier sees stable operands.
   always_comb begin
      state_d       = state_q;
      mem_a_d       = mem_a_q;
      mem_b_d       = mem_b_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      wait_d        = wait_q;
      out_valid_d   = out_valid_q;
      out_product_d = out_product_q;
      out_flags_d   = out_flags_q;
      pop           = 1'b0;
      push          = in_valid_i && in_ready_o;
      wait_inc      = wait_q + WW'(1);

      case (state_q)
         IDLE: begin
            if (count_q != '0) state_d = ISSUE;
         end
         ISSUE: begin
            wait_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            wait_d = wait_inc;
            // A done arriving on the last allowed cycle still wins over the timeout.
            if (mul_done_i) begin
               out_product_d = mul_product_i;
               out_flags_d   = {1'b0, mul_unf_i, mul_ovf_i, mul_inf_i, mul_nan_i};
               out_valid_d   = 1'b1;
               pop           = 1'b1;
               state_d       = HOLD;
            end else if (wait_inc == WW'(TIMEOUT_CYCLES)) begin
               out_product_d = 32'h0;
               out_flags_d   = 5'b10000;
               out_valid_d   = 1'b1;
               pop           = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = (count_q != '0) ? ISSUE : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      start_d = (state_d == ISSUE);

      if (push) begin
         mem_a_d[wr_ptr_q] = in_a_i;
         mem_b_d[wr_ptr_q] = in_b_i;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_a_q       <= '{default: '0};
         mem_b_q       <= '{default: '0};
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         wait_q        <= '0;
         start_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         out_product_q <= 32'h0;
         out_flags_q   <= 5'b0;
      end else begin
         state_q       <= state_d;
         mem_a_q       <= mem_a_d;
         mem_b_q       <= mem_b_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         wait_q        <= wait_d;
         start_q       <= start_d;
         out_valid_q   <= out_valid_d;
         out_product_q <= out_product_d;
         out_flags_q   <= out_flags_d;
      end
   end

endmodule

// File: tb/tb_ieee754_mult_dispatcher.sv
// Directed bench for ieee754_mult_dispatcher with a 3-cycle multiplier stand-in that can
// stall forever or report overflow.
module tb_ieee754_mult_dispatcher;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] in_a_i;
   logic [31:0] in_b_i;
   logic        mul_start_o;
   logic [31:0] mul_a_o;
   logic [31:0] mul_b_o;
   logic        mul_done_i;
   logic [31:0] mul_product_i;
   logic        mul_nan_i;
   logic        mul_inf_i;
   logic        mul_ovf_i;
   logic        mul_unf_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [31:0] out_product_o;
   logic [4:0]  out_flags_o;
   logic [2:0]  count_o;
   logic        busy_o;

   logic        done_m;
   logic [31:0] prod_m;
   logic        ovf_m;
   logic        inject_done;
   int          model_mode;
   int          pend;
   logic [31:0] ma;
   logic [31:0] mb;

   int          cyc;
   int          total_checks;
   int          passed_checks;

   ieee754_mult_dispatcher #(.DEPTH(4), .TIMEOUT_CYCLES(15)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .in_a_i        (in_a_i),
      .in_b_i        (in_b_i),
      .mul_start_o   (mul_start_o),
      .mul_a_o       (mul_a_o),
      .mul_b_o       (mul_b_o),
      .mul_done_i    (mul_done_i),
      .mul_product_i (mul_product_i),
      .mul_nan_i     (mul_nan_i),
      .mul_inf_i     (mul_inf_i),
      .mul_ovf_i     (mul_ovf_i),
      .mul_unf_i     (mul_unf_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .out_product_o (out_product_o),
      .out_flags_o   (out_flags_o),
      .count_o       (count_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   // A stray injected done carries a recognisable product and a nan flag so a wrong capture shows up.
   assign mul_done_i    = done_m | inject_done;
   assign mul_product_i = inject_done ? 32'h12345678 : prod_m;
   assign mul_nan_i     = inject_done;
   assign mul_inf_i     = 1'b0;
   assign mul_ovf_i     = ovf_m;
   assign mul_unf_i     = 1'b0;

   function automatic logic [31:0] model_product(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      return a ^ b;
   endfunction

   // Multiplier stand-in: done three cycles after the start cycle; mode 1 never answers, mode 2 overflows.
   initial begin
      done_m = 1'b0;
      prod_m = 32'h0;
      ovf_m  = 1'b0;
      pend   = 0;
      ma     = 32'h0;
      mb     = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         done_m = 1'b0;
         ovf_m  = 1'b0;
         if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0 && model_mode != 1) begin
               done_m = 1'b1;
               if (model_mode == 2) begin
                  prod_m = 32'h7FFFFFFF;
                  ovf_m  = 1'b1;
               end else begin
                  prod_m = model_product(ma, mb);
               end
            end
         end
         if (mul_start_o) begin
            pend = 3;
            ma   = mul_a_o;
            mb   = mul_b_o;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
      cyc = cyc + 1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks = total_checks + 1;
      if (got !== exp)
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      else
         passed_checks = passed_checks + 1;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
      in_valid_i = 1'b1;
      in_a_i     = a;
      in_b_i     = b;
      tick();
      in_valid_i = 1'b0;
   endtask

   task automatic waitValid(input int max_cycles, output int found);
      found = 0;
      for (int i = 0; i < max_cycles; i++) begin
         if (out_valid_o) begin
            found = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_count"},   32'(count_o), 0);
      checkOutput({tag, "_inready"}, 32'(in_ready_o), 1);
      checkOutput({tag, "_busy"},    32'(busy_o), 0);
      checkOutput({tag, "_start"},   32'(mul_start_o), 0);
      checkOutput({tag, "_mula"},    mul_a_o, 0);
      checkOutput({tag, "_mulb"},    mul_b_o, 0);
      checkOutput({tag, "_valid"},   32'(out_valid_o), 0);
      checkOutput({tag, "_prod"},    out_product_o, 0);
      checkOutput({tag, "_flags"},   32'(out_flags_o), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] fa [6];
      logic [31:0] fb [6];
      logic [31:0] qa [3];
      logic [31:0] qb [3];
      int          idx;
      int          got;
      int          last;
      int          found;
      int          t_start;
      int          t_hold;
      logic        rdy;

      cyc           = 0;
      total_checks  = 0;
      passed_checks = 0;
      reset         = 1'b1;
      in_valid_i    = 1'b0;
      in_a_i        = 32'h0;
      in_b_i        = 32'h0;
      out_ready_i   = 1'b0;
      inject_done   = 1'b0;
      model_mode    = 0;

      fa = '{32'h3F800000, 32'h40A00000, 32'hC0000000, 32'h41200000, 32'h3E800000, 32'h42C80000};
      fb = '{32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044, 32'h00000055, 32'h00000066};
      qa = '{32'h11110000, 32'h22220000, 32'h33330000};
      qb = '{32'h0000AAAA, 32'h0000BBBB, 32'h0000CCCC};

      repeat (3) tick();
      checkResetState("rst");
      reset = 1'b0;
      tick();

      // Single multiply: push in cycle 0, start in cycle 2, result in cycle 6.
      $display("[TB] single multiply");
      applyStimulus(32'h40000000, 32'h40400000);
      checkOutput("single_c1_count", 32'(count_o), 1);
      checkOutput("single_c1_start", 32'(mul_start_o), 0);
      checkOutput("single_c1_mula",  mul_a_o, 32'h40000000);
      checkOutput("single_c1_busy",  32'(busy_o), 1);
      tick();
      checkOutput("single_c2_start", 32'(mul_start_o), 1);
      checkOutput("single_c2_mulb",  mul_b_o, 32'h40400000);
      tick();
      checkOutput("single_c3_start", 32'(mul_start_o), 0);
      tick();
      tick();
      checkOutput("single_c5_valid", 32'(out_valid_o), 0);
      tick();
      checkOutput("single_c6_valid", 32'(out_valid_o), 1);
      checkOutput("single_c6_prod",  out_product_o, 32'h40C00000);
      checkOutput("single_c6_flags", 32'(out_flags_o), 0);
      checkOutput("single_c6_count", 32'(count_o), 0);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      checkOutput("single_c7_valid", 32'(out_valid_o), 0);
      checkOutput("single_c7_busy",  32'(busy_o), 0);

      // Fill with the consumer stalled: one result held plus four queued.
      $display("[TB] fill and backpressure");
      idx = 0;
      for (int i = 0; i < 20; i++) begin
         if (idx < 6) begin
            in_valid_i = 1'b1;
            in_a_i     = fa[idx];
            in_b_i     = fb[idx];
         end else begin
            in_valid_i = 1'b0;
         end
         rdy = in_ready_o;
         tick();
         if (rdy && idx < 6) idx = idx + 1;
      end
      in_valid_i = 1'b0;
      checkOutput("fill_accepted", idx, 5);
      checkOutput("fill_count",    32'(count_o), 4);
      checkOutput("fill_inready",  32'(in_ready_o), 0);
      checkOutput("fill_hold_valid", 32'(out_valid_o), 1);
      checkOutput("fill_hold_prod",  out_product_o, model_product(fa[0], fb[0]));
      out_ready_i = 1'b1;
      got  = 0;
      last = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid_o && got < 6) begin
            checkOutput($sformatf("fill_prod%0d", got), out_product_o, model_product(fa[got], fb[got]));
            if (got > 0) checkOutput($sformatf("fill_gap%0d", got), cyc - last, 5);
            last = cyc;
            got  = got + 1;
         end
         tick();
      end
      checkOutput("fill_results", got, 5);
      out_ready_i = 1'b0;

      // Timeout: the stand-in never answers the first pair.
      $display("[TB] timeout");
      model_mode  = 1;
      out_ready_i = 1'b1;
      applyStimulus(32'h01010101, 32'h02020202);
      applyStimulus(32'h03030303, 32'h04040404);
      found   = 0;
      t_start = 0;
      for (int i = 0; i < 10; i++) begin
         if (mul_start_o) begin
            found   = 1;
            t_start = cyc;
            break;
         end
         tick();
      end
      checkOutput("to_start_seen", found, 1);
      tick();
      waitValid(30, found);
      t_hold = cyc;
      checkOutput("to_valid_seen", found, 1);
      checkOutput("to_latency", t_hold - t_start, 16);
      checkOutput("to_prod",  out_product_o, 32'h0);
      checkOutput("to_flags", 32'(out_flags_o), 32'h10);
      model_mode = 0;
      tick();
      checkOutput("to_next_start", 32'(mul_start_o), 1);
      checkOutput("to_next_mula",  mul_a_o, 32'h03030303);
      checkOutput("to_next_count", 32'(count_o), 1);
      waitValid(10, found);
      checkOutput("to_next_seen", found, 1);
      checkOutput("to_next_prod", out_product_o, model_product(32'h03030303, 32'h04040404));
      tick();
      out_ready_i = 1'b0;

      // Flag pass-through, and a stray done during HOLD must not be captured.
      $display("[TB] flag pass-through");
      model_mode = 2;
      applyStimulus(32'h7F000000, 32'h7F000000);
      waitValid(20, found);
      checkOutput("ovf_seen",  found, 1);
      checkOutput("ovf_flags", 32'(out_flags_o), 32'h04);
      checkOutput("ovf_prod",  out_product_o, 32'h7FFFFFFF);
      inject_done = 1'b1;
      tick();
      inject_done = 1'b0;
      tick();
      checkOutput("stray_valid", 32'(out_valid_o), 1);
      checkOutput("stray_prod",  out_product_o, 32'h7FFFFFFF);
      checkOutput("stray_flags", 32'(out_flags_o), 32'h04);
      out_ready_i = 1'b1;
      tick();
      out_ready_i = 1'b0;
      model_mode  = 0;
      checkOutput("ovf_drain_valid", 32'(out_valid_o), 0);
      tick();
      tick();
      checkOutput("ovf_idle_valid", 32'(out_valid_o), 0);
      checkOutput("ovf_idle_busy",  32'(busy_o), 0);

      // Push and pop in the same cycle while two entries are queued.
      $display("[TB] simultaneous push and pop");
      out_ready_i = 1'b1;
      applyStimulus(qa[0], qb[0]);
      applyStimulus(qa[1], qb[1]);
      tick();
      tick();
      tick();
      checkOutput("pp_c5_count", 32'(count_o), 2);
      in_valid_i = 1'b1;
      in_a_i     = qa[2];
      in_b_i     = qb[2];
      tick();
      in_valid_i = 1'b0;
      checkOutput("pp_c6_count", 32'(count_o), 2);
      checkOutput("pp_c6_valid", 32'(out_valid_o), 1);
      checkOutput("pp_prod0",    out_product_o, model_product(qa[0], qb[0]));
      got = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (out_valid_o && got < 3) begin
            checkOutput($sformatf("pp_prod%0d", got), out_product_o, model_product(qa[got], qb[got]));
            got = got + 1;
         end
      end
      checkOutput("pp_results", got, 3);
      out_ready_i = 1'b0;

      // Reset in WAIT with three entries queued; a late done afterwards must be ignored.
      $display("[TB] reset mid-wait");
      applyStimulus(32'hAAAA0001, 32'h0000BBB1);
      applyStimulus(32'hAAAA0002, 32'h0000BBB2);
      applyStimulus(32'hAAAA0003, 32'h0000BBB3);
      tick();
      checkOutput("rw_pre_count", 32'(count_o), 3);
      reset = 1'b1;
      #1;
      checkResetState("rw");
      tick();
      reset = 1'b0;
      tick();
      inject_done = 1'b1;
      tick();
      inject_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("rw_late_valid%0d", i), 32'(out_valid_o), 0);
      end
      checkOutput("rw_late_count", 32'(count_o), 0);
      checkOutput("rw_late_prod",  out_product_o, 0);

      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule

// File: doc/ieee754_mult_dispatcher.md
# ieee754_mult_dispatcher

Operand-feeding and result-collecting stage placed directly in front of the IEEE-754 single-precision multiplier. It buffers incoming operand pairs in a small FIFO and issues them one at a time to the multiplier's start/done handshake. It captures each product and its exception flags into a valid/ready output register, and replaces a missing `done` with a timeout result so a stuck multiplier cannot hang the pipeline.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 15: maximum WAIT cycles before a timeout result; ≥ 3.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid_i`  in  1  operand pair valid.
- `in_ready_o`  out  1  FIFO not full.
- `in_a_i`, `in_b_i`  in  32 each  operands, IEEE-754 single.
- `mul_start_o`  out  1  one-cycle start pulse to multiplier.
- `mul_a_o`, `mul_b_o`  out  32 each  FIFO head operands.
- `mul_done_i`  in  1  multiplier done pulse.
- `mul_product_i`  in  32  multiplier product.
- `mul_nan_i`, `mul_inf_i`, `mul_ovf_i`, `mul_unf_i`  in  1 each  multiplier flags.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `out_product_o`  out  32  captured product.
- `out_flags_o`  out  5  {timeout, unf, ovf, inf, nan}.
- `count_o`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `busy_o`  out  1  state ≠ IDLE or FIFO non-empty.

## Operation
- FIFO:
  - Push when `in_valid_i && in_ready_o`.
  - `in_ready_o = (count < DEPTH)` from registered count; no pass-through when full.
  - Pop only on result capture (done or timeout).
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- `mul_a_o`/`mul_b_o` present the FIFO head continuously; the head is stable from ISSUE until pop. Empty FIFO drives 0.
- FSM:
  - IDLE: if count > 0, go to ISSUE.
  - ISSUE: `mul_start_o` = 1 for exactly this cycle; clear wait counter; go to WAIT.
  - WAIT: the wait counter increments each cycle (first WAIT cycle = 1).
    - If `mul_done_i` = 1: capture `mul_product_i` and flags, with timeout = 0; pop; go to HOLD.
    - Else, if counter == TIMEOUT_CYCLES: capture product 32'h0 and flags 5'b10000; pop; go to HOLD.
    - `mul_done_i` takes priority over timeout in the same cycle.
  - HOLD: `out_valid_o` = 1. On `out_ready_i`:
    - count > 0: go to ISSUE (back-to-back).
    - otherwise: go to IDLE.
- `mul_done_i` is ignored outside WAIT.
- The output register holds its value while `out_valid_o && !out_ready_i`.
- Flags pass through unmodified; nan/inf/ovf/unf are not re-derived.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - State IDLE; FIFO empty.
  - `count_o` = 0, `in_ready_o` = 1, `busy_o` = 0.
  - `mul_start_o` = 0, `mul_a_o` = `mul_b_o` = 0.
  - `out_valid_o` = 0, `out_product_o` = 0, `out_flags_o` = 0.
- Reset mid-operation discards FIFO contents and any in-flight operation; a stray `mul_done_i` after reset is ignored. The multiplier is reset on the same net.
- Nominal multiplier: `mul_done_i` arrives 3 cycles after the `mul_start_o` cycle.
- Latency: push sampled at end of cycle 0 gives the following schedule.
  - cycle 1: IDLE
  - cycle 2: ISSUE
  - cycles 3–5: WAIT (done in cycle 5)
  - cycle 6: `out_valid_o` = 1
- Throughput with `out_ready_i` held high and the FIFO kept non-empty: one result every 5 cycles (ISSUE, WAIT×3, HOLD).
- Timeout result appears in HOLD the cycle after WAIT cycle number TIMEOUT_CYCLES.

## Test plan
- **Single multiply:** push a=0x40000000, b=0x40400000 at cycle 0.
  - `mul_start_o` pulses in cycle 2.
  - `out_valid_o` in cycle 6 with product 0x40C00000, flags 0.
- **Fill/backpressure:** `out_ready_i` = 0; push 6 pairs.
  - `in_ready_o` drops after the FIFO is full (count 4 plus 1 in flight).
  - The first result holds stable in HOLD.
  - Release `out_ready_i`: all 5 accepted pairs emerge in order, 5-cycle spacing.
- **Timeout:** bench model never raises `mul_done_i`.
  - After 15 WAIT cycles: product 0x00000000, flags 5'b10000.
  - FIFO pops and the next pair issues.
- **Flag pass-through:** model returns done with `mul_ovf_i` = 1, product 0x7FFFFFFF.
  - Output flags 5'b00100, product 0x7FFFFFFF.
  - A done pulse injected during HOLD is ignored.
- **Simultaneous push/pop:** in_valid held while the WAIT done capture occurs with count 2.
  - count stays 2; ordering preserved.
- **Reset mid-WAIT:** assert `reset` in WAIT with 3 entries queued.
  - All outputs return to reset values immediately.
  - A late `mul_done_i` produces no output.
